pwm_multi: RTL and testbench

Parametrised multi-channel PWM generator and successor to the single-channel 8-bit `pwm`. It drives `CHANNELS` outputs from one shared prescaled timebase. Duty values are double-buffered: writes go to a shadow register and take effect only at a period boundary, so outputs never glitch. It supports edge-aligned and center-aligned modes, plus per-channel enable and polarity. It sits between the control/register logic and the motor/LED output pins.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_timebase.sv | 74 +++++++
 rtl/pwm_multi.sv | 69 ++++++
 tb/tb_pwm_multi.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
package pwm_pkg;

  localparam logic PWM_MODE_EDGE   = 1'b0;
  localparam logic PWM_MODE_CENTER = 1'b1;

  typedef enum logic {
    PWM_DIR_UP   = 1'b0,
    PWM_DIR_DOWN = 1'b1
  } pwm_dir_e;

  // Full-scale duty value for a given compare width.
  function automatic int unsigned pwm_max(input int unsigned res);
    return (32'd1 << res) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, period counter, ramp direction and latched mode.
//   state         | meaning
//   dir=UP        | counting 0..M-1; cnt==0 on a tick marks the period boundary
//   dir=DOWN      | center mode only, counting M-1..0 back towards the boundary
//   mode=EDGE     | wrap from M-1 to 0, period M ticks
//   mode=CENTER   | turn around at M-1 and at 0, period 2M ticks
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int RES      = 8,
  parameter int PRESCALE = 50
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           center,
  output logic           tick,
  output logic [RES-1:0] cnt,
  output logic           boundary
);

  localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [RES-1:0]  CNT_TOP = RES'(pwm_max(RES) - 1);

  logic [PS_W-1:0] ps, ps_nxt;
  logic [RES-1:0]  cnt_nxt;
  pwm_dir_e        dir, dir_nxt;
  logic            mode, mode_nxt;

  // Prescaler is a down-counter; terminal count zero is the tick.
  assign tick     = (ps == '0);
  assign boundary = tick && (cnt == '0) && (dir == PWM_DIR_UP);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ps   <= PS_LAST;
      cnt  <= '0;
      dir  <= PWM_DIR_UP;
      mode <= PWM_MODE_EDGE;
    end else begin
      ps   <= ps_nxt;
      cnt  <= cnt_nxt;
      dir  <= dir_nxt;
      mode <= mode_nxt;
    end
  end

  always_comb begin
    ps_nxt   = tick ? PS_LAST : ps - PS_W'(1);
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    mode_nxt = mode;
    if (tick) begin
      if (boundary) mode_nxt = center;
      unique case (dir)
        PWM_DIR_UP: begin
          if (cnt == CNT_TOP) begin
            // End values are held for a second tick while the direction flips.
            if (mode == PWM_MODE_CENTER) dir_nxt = PWM_DIR_DOWN;
            else                         cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + RES'(1);
          end
        end
        PWM_DIR_DOWN: begin
          if (cnt == '0) dir_nxt = PWM_DIR_UP;
          else           cnt_nxt = cnt - RES'(1);
        end
        default: dir_nxt = PWM_DIR_UP;
      endcase
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with double-buffered duties on a shared timebase.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int RES      = 8,
  parameter int PRESCALE = 50,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                wrEn,
  input  logic [CH_W-1:0]     wrCh,
  input  logic [RES-1:0]      wrDuty,
  input  logic [CHANNELS-1:0] chEn,
  input  logic [CHANNELS-1:0] chInv,
  input  logic                center,
  output logic [CHANNELS-1:0] pwmOut,
  output logic                periodStart
);

  logic           tick;
  logic           boundary;
  logic [RES-1:0] cnt;
  logic [CHANNELS-1:0] pwm_nxt;

  pwm_timebase #(
    .RES      (RES),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .CLK      (CLK),
    .RST      (RST),
    .center   (center),
    .tick     (tick),
    .cnt      (cnt),
    .boundary (boundary)
  );

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [RES-1:0] shadow;
    logic [RES-1:0] act;
    logic [RES-1:0] duty;

    // On the boundary tick the compare already uses the value being loaded.
    assign duty       = boundary ? shadow : act;
    assign pwm_nxt[i] = chEn[i] ? ((cnt < duty) ^ chInv[i]) : chInv[i];

    always_ff @(posedge CLK) begin
      if (RST) begin
        shadow <= '0;
        act    <= '0;
      end else begin
        if (wrEn && (wrCh == CH_W'(i))) shadow <= wrDuty;
        if (boundary)                   act    <= shadow;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwmOut      <= '0;
      periodStart <= 1'b0;
    end else begin
      periodStart <= boundary;
      if (tick) pwmOut <= pwm_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi with CHANNELS=4, RES=4 (M=15), PRESCALE=2.
module tb_pwm_multi;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       wrEn = 1'b0;
  logic [1:0] wrCh = '0;
  logic [3:0] wrDuty = '0;
  logic [3:0] chEn = 4'hF;
  logic [3:0] chInv = 4'h0;
  logic       center = 1'b0;
  logic [3:0] pwmOut;
  logic       periodStart;

  int checks = 0;
  int errors = 0;
  int hi[4];
  int len;
  int n;
  logic [3:0] last;

  pwm_multi #(
    .CHANNELS (4),
    .RES      (4),
    .PRESCALE (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .wrEn        (wrEn),
    .wrCh        (wrCh),
    .wrDuty      (wrDuty),
    .chEn        (chEn),
    .chInv       (chInv),
    .center      (center),
    .pwmOut      (pwmOut),
    .periodStart (periodStart)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic write_ch(input logic [1:0] ch, input logic [3:0] d);
    wrEn   = 1'b1;
    wrCh   = ch;
    wrDuty = d;
    @(negedge CLK);
    wrEn   = 1'b0;
  endtask

  // Steps to the next negedge showing periodStart; cnt = negedges stepped.
  task automatic wait_ps(output int cnt);
    cnt = 0;
    do begin
      @(negedge CLK);
      cnt++;
    end while (periodStart !== 1'b1 && cnt < 200);
    chk("wait_period_start", periodStart, 1);
  endtask

  // Starting on a periodStart negedge, samples one full period of outputs.
  task measure();
    for (int k = 0; k < 4; k++) hi[k] = 0;
    len = 0;
    do begin
      for (int k = 0; k < 4; k++) hi[k] += int'(pwmOut[k]);
      last = pwmOut;
      len++;
      @(negedge CLK);
    end while (periodStart !== 1'b1 && len < 200);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_pwmOut", pwmOut, 0);
    chk("rst_periodStart", periodStart, 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("cycle0_periodStart", periodStart, 0);
    @(negedge CLK);
    chk("cycle1_periodStart", periodStart, 1);
    chk("idle_pwmOut", pwmOut, 0);
    measure();
    chk("idle_len1", len, 30);
    chk("idle_hi", hi[0] + hi[1] + hi[2] + hi[3], 0);
    measure();
    chk("idle_len2", len, 30);

    // Edge-aligned duties
    write_ch(2'd0, 4'd0);
    write_ch(2'd1, 4'd5);
    write_ch(2'd2, 4'd15);
    write_ch(2'd3, 4'd8);
    wait_ps(n);
    chk("edge_first_tick", pwmOut, 4'b1110);
    measure();
    chk("edge_len", len, 30);
    chk("edge_ch0_hi", hi[0] / 2, 0);
    chk("edge_ch1_hi", hi[1] / 2, 5);
    chk("edge_ch2_hi", hi[2] / 2, 15);
    chk("edge_ch3_hi", hi[3] / 2, 8);
    chk("edge_last_tick", last, 4'b0100);

    // Double buffering: second write coincides with the boundary
    write_ch(2'd1, 4'd5);
    repeat (28) @(negedge CLK);
    wrEn   = 1'b1;
    wrCh   = 2'd1;
    wrDuty = 4'd10;
    @(negedge CLK);
    wrEn   = 1'b0;
    chk("dbuf_boundary", periodStart, 1);
    measure();
    chk("dbuf_old_hi", hi[1] / 2, 5);
    measure();
    chk("dbuf_new_hi", hi[1] / 2, 10);

    // Center-aligned mode, switched mid-period
    center = 1'b1;
    write_ch(2'd0, 4'd4);
    wait_ps(n);
    chk("edge_len_before_switch", n, 29);
    chk("center_first_tick", pwmOut[0], 1);
    measure();
    chk("center_len", len, 60);
    chk("center_ch0_hi", hi[0] / 2, 8);
    chk("center_ch1_hi", hi[1] / 2, 20);
    chk("center_ch2_hi", hi[2] / 2, 30);
    chk("center_ch3_hi", hi[3] / 2, 16);
    chk("center_ch0_last", last[0], 1);
    center = 1'b0;
    measure();
    chk("center_hold_len", len, 60);

    // Enable / invert take effect on the next tick
    write_ch(2'd2, 4'd5);
    wait_ps(n);
    chk("edge_restore_len", n, 29);
    repeat (3) @(negedge CLK);
    chk("inv_before", pwmOut[2], 1);
    chInv[2] = 1'b1;
    @(negedge CLK);
    chk("inv_after", pwmOut[2], 0);
    chEn[2] = 1'b0;
    @(negedge CLK);
    chk("dis_hold_until_tick", pwmOut[2], 0);
    @(negedge CLK);
    chk("dis_idle_level", pwmOut[2], 1);
    chEn  = 4'hF;
    chInv = 4'h0;
    repeat (3) @(negedge CLK);
    chk("pre_reset_pwmOut", pwmOut, 4'b1110);

    // Reset in the middle of a period
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_pwmOut", pwmOut, 0);
    chk("midrst_periodStart", periodStart, 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_cycle0_ps", periodStart, 0);
    @(negedge CLK);
    chk("midrst_cycle1_ps", periodStart, 1);
    chk("midrst_first_pwmOut", pwmOut, 0);
    measure();
    chk("midrst_len", len, 30);
    chk("midrst_hi", hi[0] + hi[1] + hi[2] + hi[3], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
